wb_mem_to_stream: RTL and testbench

//  DMA engine, memory -> stream: reads a linear buffer from memory with Wishbone B3 incrementing

---
 rtl/wb_mem_to_stream.sv | 183 ++++++++++++++++++
 tb/tb_wb_mem_to_stream.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_to_stream.sv
// Memory-to-stream DMA: Wishbone B3 incrementing read bursts into a FWFT FIFO drained on valid/ready.
// A burst is only issued once the FIFO has room for every beat of it, so acks are never refused.
module wb_mem_to_stream #(
  parameter int WB_DW         = 32,
  parameter int WB_AW         = 32,
  parameter int FIFO_AW       = 4,
  parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [WB_AW-1:0]     wbm_adr_o,
  output logic [WB_DW-1:0]     wbm_dat_o,
  output logic [WB_DW/8-1:0]   wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  output logic [WB_DW-1:0]     stream_m_data_o,
  output logic                 stream_m_valid_o,
  input  logic                 stream_m_ready_i,
  input  logic                 enable,
  input  logic [WB_AW-1:0]     start_adr,
  input  logic [WB_AW-1:0]     buf_size,
  input  logic [WB_AW-1:0]     burst_size,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WB_AW-1:0]     tx_cnt
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam int LIM   = (MAX_BURST_LEN < 1) ? 1 : ((MAX_BURST_LEN < DEPTH) ? MAX_BURST_LEN : DEPTH);
  localparam logic [WB_AW-1:0] LIM_W = WB_AW'(LIM);
  localparam logic [WB_AW-1:0] BPW   = WB_AW'(WB_DW/8);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [WB_AW-1:0]     start_adr_q, start_adr_d;
  logic [WB_AW-1:0]     buf_size_q, buf_size_d;
  logic [WB_AW-1:0]     burst_size_q, burst_size_d;
  logic [WB_AW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [FIFO_AW:0]     left_q, left_d;
  logic                 cyc_q, cyc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [WB_DW-1:0]     mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     count_q;
  logic [FIFO_AW:0]     free;
  logic [WB_AW-1:0]     rem, blen;
  logic                 push, pop, empty;

  assign empty = (count_q == '0);
  assign free  = (FIFO_AW+1)'(DEPTH) - count_q;
  assign push  = cyc_q && wbm_ack_i && !wbm_err_i;
  assign pop   = !empty && stream_m_ready_i;

  // Beats for the next burst: requested size, clipped by words left and FIFO depth.
  always_comb begin
    rem  = buf_size_q - tx_cnt_q;
    blen = burst_size_q;
    if (rem < blen) blen = rem;
    if (LIM_W < blen) blen = LIM_W;
  end

  always_comb begin
    state_d      = state_q;
    start_adr_d  = start_adr_q;
    buf_size_d   = buf_size_q;
    burst_size_d = burst_size_q;
    tx_cnt_d     = tx_cnt_q;
    left_d       = left_q;
    cyc_d        = cyc_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          start_adr_d  = start_adr;
          buf_size_d   = buf_size;
          burst_size_d = (burst_size == '0) ? WB_AW'(1) : burst_size;
          tx_cnt_d     = '0;
          err_d        = 1'b0;
          if (buf_size == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (blen[FIFO_AW:0] <= free) begin
          left_d  = blen[FIFO_AW:0];
          cyc_d   = 1'b1;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (wbm_err_i) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end else if (wbm_ack_i) begin
          tx_cnt_d = tx_cnt_q + WB_AW'(1);
          left_d   = left_q - (FIFO_AW+1)'(1);
          if (left_q == (FIFO_AW+1)'(1)) begin
            cyc_d   = 1'b0;
            state_d = (tx_cnt_d == buf_size_q) ? S_DRAIN : S_WAIT;
          end
        end
      end
      default: begin
        if (empty) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_adr_q  <= '0;
      buf_size_q   <= '0;
      burst_size_q <= '0;
      tx_cnt_q     <= '0;
      left_q       <= '0;
      cyc_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      start_adr_q  <= start_adr_d;
      buf_size_q   <= buf_size_d;
      burst_size_q <= burst_size_d;
      tx_cnt_q     <= tx_cnt_d;
      left_q       <= left_d;
      cyc_q        <= cyc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      if (push && !pop)      count_q <= count_q + (FIFO_AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (FIFO_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wbm_dat_i;
  end

  assign wbm_adr_o        = cyc_q ? (start_adr_q + tx_cnt_q * BPW) : '0;
  assign wbm_dat_o        = '0;
  assign wbm_sel_o        = {(WB_DW/8){cyc_q}};
  assign wbm_we_o         = 1'b0;
  assign wbm_cyc_o        = cyc_q;
  assign wbm_stb_o        = cyc_q;
  assign wbm_cti_o        = !cyc_q ? 3'b000 : ((left_q == (FIFO_AW+1)'(1)) ? 3'b111 : 3'b010);
  assign wbm_bte_o        = 2'b00;
  assign stream_m_data_o  = empty ? '0 : mem[rd_ptr_q];
  assign stream_m_valid_o = !empty;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign tx_cnt           = tx_cnt_q;

endmodule

// File: tb/tb_wb_mem_to_stream.sv
// Bench for wb_mem_to_stream: random Wishbone slave and sink, queue-based word model checked every cycle.
module tb_wb_mem_to_stream;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] stream_m_data_o;
  logic        stream_m_valid_o, stream_m_ready_i;
  logic        enable, busy, done, err;
  logic [31:0] start_adr, buf_size, burst_size, tx_cnt;

  wb_mem_to_stream #(.WB_DW(32), .WB_AW(32), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .stream_m_data_o(stream_m_data_o), .stream_m_valid_o(stream_m_valid_o),
    .stream_m_ready_i(stream_m_ready_i),
    .enable(enable), .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size),
    .busy(busy), .done(done), .err(err), .tx_cnt(tx_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Reference model state
  logic        m_active = 0, m_err = 0, zero_exp = 0;
  logic [31:0] m_start = 0, m_buf = 0, m_burst = 0, m_tx = 0, m_L = 0, m_beat = 0;
  logic [31:0] q[$];
  logic [31:0] popped[$];
  logic [31:0] burst_adr[$];
  int          burst_beats[$];
  logic [2:0]  cti_log[$];
  int          done_cnt = 0;

  int          ready_mode = 1, ack_pct = 100, err_at = 0;
  logic        err_en = 0;

  logic        p_rst = 0, p_en = 0, p_cyc = 0, p_ack = 0, p_err = 0, p_pop = 0;
  logic [31:0] p_adr = 0, p_buf = 0, p_bsz = 0;
  logic [2:0]  p_cti = 0;

  // Slave/sink driver and per-cycle compare against the model
  initial begin
    logic [31:0] rem, exp_adr;
    wbm_ack_i = 0; wbm_err_i = 0; stream_m_ready_i = 0; wbm_dat_i = 0;
    forever begin
      @(negedge clk);
      if (p_rst) begin
        m_active = 0; m_err = 0; m_tx = 0; m_beat = 0; zero_exp = 0;
        q.delete();
        check("reset_ctrl", {wbm_cyc_o, wbm_stb_o, wbm_sel_o, wbm_cti_o, stream_m_valid_o, busy, done, err}, 0);
        check("reset_adr_tx", {wbm_adr_o, tx_cnt}, 0);
        check("reset_data", stream_m_data_o, 0);
      end else begin
        if (p_pop) begin
          check("pop_nonempty", q.size() != 0, 1);
          if (q.size() != 0) popped.push_back(q.pop_front());
        end
        if (p_cyc && p_err) m_err = 1;
        else if (p_cyc && p_ack) begin
          exp_adr = m_start + m_tx * 32'd4;
          q.push_back(mem_word(exp_adr));
          cti_log.push_back(p_cti);
          if (burst_beats.size() != 0) burst_beats[burst_beats.size()-1] += 1;
          m_tx++;
          m_beat++;
        end
        if (p_en && !m_active) begin
          m_start = p_adr; m_buf = p_buf; m_burst = (p_bsz == 0) ? 32'd1 : p_bsz;
          m_tx = 0; m_err = 0;
          if (p_buf == 0) zero_exp = 1;
          else m_active = 1;
        end

        check("valid", stream_m_valid_o, q.size() != 0);
        if (q.size() != 0) check("data", stream_m_data_o, q[0]);
        check("tx_cnt", tx_cnt, m_tx);
        check("err", err, m_err);
        check("bus_static", {wbm_stb_o, wbm_sel_o, wbm_we_o, wbm_bte_o, wbm_dat_o},
              {wbm_cyc_o, {4{wbm_cyc_o}}, 1'b0, 2'b00, 32'h0});
        if (zero_exp) begin
          check("zero_done", {done, busy, wbm_cyc_o}, 3'b100);
          if (done) done_cnt++;
          zero_exp = 0;
        end else if (done) begin
          check("done_ok", {m_active, q.size() == 0, (m_tx == m_buf) || m_err}, 3'b111);
          m_active = 0;
          done_cnt++;
        end
        check("busy", busy, m_active);
        if (wbm_cyc_o) begin
          if (!p_cyc) begin
            rem = m_buf - m_tx;
            m_L = m_burst;
            if (rem < m_L) m_L = rem;
            if (DEPTH < m_L) m_L = DEPTH;
            m_beat = 0;
            burst_adr.push_back(wbm_adr_o);
            burst_beats.push_back(0);
            check("fifo_room", (q.size() + m_L) <= DEPTH, 1);
          end
          check("cyc_allowed", {m_active, m_err, m_beat < m_L}, 3'b101);
          exp_adr = m_start + m_tx * 32'd4;
          check("adr", wbm_adr_o, exp_adr);
          check("cti", wbm_cti_o, (m_beat == m_L - 1) ? 3'b111 : 3'b010);
        end else begin
          check("cti_idle", wbm_cti_o, 0);
        end
      end

      case (ready_mode)
        0:       stream_m_ready_i = 0;
        1:       stream_m_ready_i = 1;
        default: stream_m_ready_i = ($urandom_range(0, 1) == 1);
      endcase
      if (err_en && wbm_cyc_o && m_tx == err_at) begin
        wbm_err_i = 1; wbm_ack_i = 1; err_en = 0;
      end else begin
        wbm_err_i = 0;
        wbm_ack_i = wbm_cyc_o && ($urandom_range(0, 99) < ack_pct);
      end
      wbm_dat_i = mem_word(wbm_adr_o);

      p_rst = rst; p_en = enable; p_adr = start_adr; p_buf = buf_size; p_bsz = burst_size;
      p_cyc = wbm_cyc_o; p_ack = wbm_ack_i; p_err = wbm_err_i; p_cti = wbm_cti_o;
      p_pop = stream_m_valid_o && stream_m_ready_i;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    tick(1);
    start_adr = a; buf_size = b; burst_size = s; enable = 1;
    tick(1);
    enable = 0;
  endtask

  task automatic wait_done(input int budget);
    int base, n;
    base = done_cnt; n = 0;
    while (done_cnt == base && n < budget) begin tick(1); n++; end
    check("done_timeout", done_cnt != base, 1);
  endtask

  task automatic clear_logs();
    popped.delete(); burst_adr.delete(); burst_beats.delete(); cti_log.delete();
  endtask

  initial begin
    logic [23:0] ctis;
    logic [31:0] b;
    int n;
    rst = 1; enable = 0; start_adr = 0; buf_size = 0; burst_size = 0;
    tick(3);
    rst = 0;
    tick(2);

    // Two 4-beat bursts, sink always ready
    clear_logs(); ready_mode = 1; ack_pct = 100;
    start(32'h1000, 8, 4);
    wait_done(300);
    check("t1_nbursts", burst_adr.size(), 2);
    if (burst_adr.size() == 2) check("t1_burst_adr", {burst_adr[0], burst_adr[1]}, {32'h1000, 32'h1010});
    ctis = 0;
    foreach (cti_log[i]) ctis = {ctis[20:0], cti_log[i]};
    check("t1_cti_seq", {cti_log.size(), ctis}, {32'd8, 24'b010_010_010_111_010_010_010_111});
    check("t1_npopped", popped.size(), 8);
    if (popped.size() == 8) check("t1_words", {popped[0], popped[7]}, {32'hDEAD1000, 32'hDEAD101C});
    check("t1_busy", busy, 0);

    // Sink stalled: only one FIFO-sized burst, then the rest after draining
    clear_logs(); ready_mode = 0;
    start(32'h2000, 7, 5);
    tick(30);
    check("t2_first_burst", {burst_beats.size(), (burst_beats.size() > 0) ? burst_beats[0] : -1}, {32'd1, 32'd4});
    check("t2_stalled", {wbm_cyc_o, tx_cnt}, {1'b0, 32'd4});
    ready_mode = 2;
    wait_done(500);
    check("t2_second_burst", {burst_beats.size(), (burst_beats.size() > 1) ? burst_beats[1] : -1}, {32'd2, 32'd3});

    // Random transfers with random ready and ack, including an address wrap
    ready_mode = 2; ack_pct = 60;
    for (int i = 0; i < 12; i++) begin
      clear_logs();
      b = $urandom_range(1, 20);
      start((i == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC), b, $urandom_range(0, 6));
      wait_done(2000);
      check("t3_count", popped.size(), b);
    end

    // Bus error on beat 3 of 4 (ack raised alongside err)
    clear_logs(); ack_pct = 100; err_en = 1; err_at = 2;
    start(32'h5000, 4, 4);
    wait_done(300);
    check("t4_err_tx", {err, tx_cnt}, {1'b1, 32'd2});
    check("t4_npopped", popped.size(), 2);

    // Zero-length transfer, then enable while busy
    clear_logs(); ready_mode = 1;
    start(32'h6000, 0, 3);
    wait_done(10);
    check("t5_no_cyc", burst_adr.size(), 0);
    clear_logs(); ready_mode = 0;
    start(32'h3000, 6, 2);
    tick(20);
    start(32'h9000, 1, 1);
    tick(5);
    ready_mode = 2;
    wait_done(500);
    check("t5_npopped", popped.size(), 6);
    if (popped.size() > 0) check("t5_first", popped[0], 32'hDEAD3000);

    // Reset in the middle of a burst, then a clean transfer
    ready_mode = 1; ack_pct = 30;
    start(32'h7000, 16, 4);
    n = 0;
    while (!(wbm_cyc_o && m_tx >= 3) && n < 300) begin tick(1); n++; end
    check("t6_midburst_timeout", wbm_cyc_o && m_tx >= 3, 1);
    rst = 1;
    tick(2);
    rst = 0;
    tick(1);
    check("t6_after_reset", {wbm_cyc_o, stream_m_valid_o, busy, tx_cnt}, 0);
    clear_logs(); ack_pct = 100;
    start(32'h4000, 5, 3);
    wait_done(300);
    check("t6_npopped", popped.size(), 5);
    if (burst_adr.size() > 0) check("t6_first_adr", burst_adr[0], 32'h4000);
    if (popped.size() > 0) check("t6_first", popped[0], 32'hDEAD4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
